// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
//   Shared definitions for the score overlay: display constants, the digit
//   encoder state type and the 6-bit glyph letter code type that is also used
//   by the score letter mux.
// -----------------------------------------------------------------------------
package score_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned MAX_SCORE  = 9999;

  typedef logic [5:0] letter_code_t;

  localparam letter_code_t DIGIT_BASE = 6'd16;
  localparam letter_code_t BLANK_CODE = 6'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    PENDING = 2'd2
  } score_enc_state_t;

  // Glyph code for a decimal digit, given the code of glyph '0'.
  function automatic letter_code_t digit_code(input logic [3:0] d,
                                              input letter_code_t base);
    return base + letter_code_t'(d);
  endfunction

endpackage

// File: rtl/score_bcd_add3.sv
// -----------------------------------------------------------------------------
// score_bcd_add3
//   Combinational double-dabble nibble correction: values of 5 or more get 3
//   added so that the following left shift carries correctly into the next
//   decimal digit. Never produces a carry out of the nibble.
//   din  : BCD nibble before correction
//   dout : corrected nibble
// -----------------------------------------------------------------------------
module score_bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? (din + 4'd3) : din;
  end

endmodule

// File: rtl/score_digit_encoder.sv
// -----------------------------------------------------------------------------
// score_digit_encoder
//   Converts the binary game score to per-digit glyph letter codes using a
//   sequential shift-and-add-3 conversion, blanks leading zeros, and commits
//   the new digits only at start-of-frame so a frame never shows a partially
//   updated score.
//
//   clk          : system/pixel clock
//   resetN       : asynchronous active-low reset
//   score        : binary score, may change on any cycle
//   startOfFrame : one-cycle frame start pulse, the commit point
//   digitCodes   : letter codes, [5:0] units, [11:6] tens, ...
//   busy         : conversion running or waiting for the commit point
//   updated      : one-cycle pulse after digitCodes was loaded
//   overflow     : last committed score was saturated to MAX_SCORE
// -----------------------------------------------------------------------------
module score_digit_encoder #(
  parameter int unsigned            SCORE_W    = 14,
  parameter int unsigned            NUM_DIGITS = score_pkg::NUM_DIGITS,
  parameter int unsigned            MAX_SCORE  = score_pkg::MAX_SCORE,
  parameter score_pkg::letter_code_t DIGIT_BASE = score_pkg::DIGIT_BASE,
  parameter score_pkg::letter_code_t BLANK_CODE = score_pkg::BLANK_CODE,
  parameter bit                     LEAD_BLANK = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [SCORE_W-1:0]        score,
  input  logic                      startOfFrame,
  output logic [6*NUM_DIGITS-1:0]   digitCodes,
  output logic                      busy,
  output logic                      updated,
  output logic                      overflow
);

  import score_pkg::*;

  localparam int unsigned        BCD_W    = 4 * NUM_DIGITS;
  localparam int unsigned        CNT_W    = $clog2(SCORE_W + 1);
  localparam logic [SCORE_W-1:0] MAX_VAL  = SCORE_W'(MAX_SCORE);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(SCORE_W - 1);

  // Display value shown out of reset: a single "0" in the units position.
  function automatic logic [6*NUM_DIGITS-1:0] zero_codes();
    logic [6*NUM_DIGITS-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      r[6*i +: 6] = (i == 0 || !LEAD_BLANK) ? DIGIT_BASE : BLANK_CODE;
    end
    return r;
  endfunction

  localparam logic [6*NUM_DIGITS-1:0] RESET_CODES = zero_codes();

  score_enc_state_t        state;
  score_enc_state_t        nextState;

  logic [SCORE_W-1:0]      shiftBin;
  logic [BCD_W-1:0]        bcd;
  logic [BCD_W-1:0]        bcdAdj;
  logic [CNT_W-1:0]        bitCnt;
  logic [SCORE_W-1:0]      rawCap;
  logic [SCORE_W-1:0]      lastScore;
  logic                    ovfNext;

  logic                    startConv;
  logic                    commit;
  logic [6*NUM_DIGITS-1:0] blankedCodes;
  logic                    seenNz;
  logic [3:0]              nib;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (score != lastScore)   nextState = CONVERT;
      CONVERT: if (bitCnt == LAST_BIT)   nextState = PENDING;
      PENDING: if (startOfFrame)         nextState = IDLE;
      default:                           nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state != IDLE);
    startConv = (state == IDLE) && (score != lastScore);
    commit    = (state == PENDING) && startOfFrame;
  end

  // ---------------------------------------------------------------------------
  // Per-nibble add-3 correction ahead of each shift
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    score_bcd_add3 u_add3 (
      .din  (bcd[4*g +: 4]),
      .dout (bcdAdj[4*g +: 4])
    );
  end

  // ---------------------------------------------------------------------------
  // Conversion datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      shiftBin  <= '0;
      bcd       <= '0;
      bitCnt    <= '0;
      rawCap    <= '0;
      ovfNext   <= 1'b0;
      lastScore <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startConv) begin
            shiftBin <= (score > MAX_VAL) ? MAX_VAL : score;
            bcd      <= '0;
            bitCnt   <= '0;
            rawCap   <= score;
            ovfNext  <= (score > MAX_VAL);
          end
        end
        CONVERT: begin
          // {bcd, shiftBin} shifted left by one, bcd taken from its corrected form
          bcd      <= {bcdAdj[BCD_W-2:0], shiftBin[SCORE_W-1]};
          shiftBin <= shiftBin << 1;
          bitCnt   <= bitCnt + CNT_W'(1);
        end
        PENDING: begin
          // The raw value, not the saturated one, so an unchanged
          // over-range score does not retrigger a conversion.
          if (startOfFrame) begin
            lastScore <= rawCap;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking, scanned from the most significant digit down.
  // The units digit always counts as significant.
  // ---------------------------------------------------------------------------
  always_comb begin
    blankedCodes = '0;
    seenNz       = 1'b0;
    nib          = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      nib = bcd[4*(NUM_DIGITS-1-k) +: 4];
      if (nib != 4'd0 || k == NUM_DIGITS - 1) begin
        seenNz = 1'b1;
      end
      blankedCodes[6*(NUM_DIGITS-1-k) +: 6] =
        (LEAD_BLANK && !seenNz) ? BLANK_CODE : digit_code(nib, DIGIT_BASE);
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers, loaded only at the commit point
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digitCodes <= RESET_CODES;
      updated    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      updated <= commit;
      if (commit) begin
        digitCodes <= blankedCodes;
        overflow   <= ovfNext;
      end
    end
  end

endmodule
